la_capture_stream: RTL and testbench

// - Logic-analyzer capture front end; sole source of the LA upstream port (la_as_*, la_hpri_req) of the AXIS switch.
// - Watches masked la_data and pushes one word per value change into an 8-entry FIFO.
// - Drains the FIFO as AXI-Stream bursts towards the switch.
// - Raises la_hpri_req when the backlog reaches a programmable level.

---
 rtl/la_capture_stream_if.sv | 26 ++
 rtl/la_capture_stream.sv | 173 +++++++++++++++++
 tb/tb_la_capture_stream.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/la_capture_stream_if.sv
// Upstream AXI-Stream port from the logic-analyzer capture block towards the
// AXIS switch, including the high-priority request line to the switch arbiter.
interface la_capture_stream_if #(
    parameter int pDATA_WIDTH = 32
);
    logic [pDATA_WIDTH-1:0]   la_as_tdata;
    logic [pDATA_WIDTH/8-1:0] la_as_tstrb;
    logic [pDATA_WIDTH/8-1:0] la_as_tkeep;
    logic                     la_as_tlast;
    logic                     la_as_tvalid;
    logic [1:0]               la_as_tuser;
    logic                     la_hpri_req;
    logic                     as_la_tready;

    modport master (
        output la_as_tdata, la_as_tstrb, la_as_tkeep, la_as_tlast,
               la_as_tvalid, la_as_tuser, la_hpri_req,
        input  as_la_tready
    );

    modport slave (
        input  la_as_tdata, la_as_tstrb, la_as_tkeep, la_as_tlast,
               la_as_tvalid, la_as_tuser, la_hpri_req,
        output as_la_tready
    );
endinterface

// File: rtl/la_capture_stream.sv
// Logic-analyzer capture front end: detects masked changes on la_data, queues
// one word per change in a small first-word-fall-through FIFO and drains it
// as fixed-length AXI-Stream packets. Word format: {ovf, delta, sample}.
// Optional build macro LA_CAPTURE_HEARTBEAT_EN: emit a keep-alive word when
// delta reaches its saturation value with no change on the probes.
module la_capture_stream #(
    parameter int pDATA_WIDTH = 32,
    parameter int pLA_WIDTH   = 24,
    parameter int pFIFO_DEPTH = 8,
    parameter int pBURST      = 4
) (
    input  logic                 axis_clk,
    input  logic                 axis_rst,
    input  logic [pLA_WIDTH-1:0] la_data,
    input  logic                 cfg_en,
    input  logic [pLA_WIDTH-1:0] cfg_mask,
    input  logic [3:0]           cfg_hpri_th,
    la_capture_stream_if.master  la_as,
    output logic [3:0]           sts_level,
    output logic                 sts_ovf
);
    localparam int PTR_W  = $clog2(pFIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int BEAT_W = (pBURST > 1) ? $clog2(pBURST) : 1;
    localparam int DLT_W  = pDATA_WIDTH - pLA_WIDTH - 1;

    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(pFIFO_DEPTH);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(pBURST - 1);
    localparam logic [DLT_W-1:0]  DLT_MAX   = {DLT_W{1'b1}};

    logic [pLA_WIDTH-1:0]   la_q;
    logic                   smp_vld_q;
    logic [pLA_WIDTH-1:0]   base_q,     base_d;
    logic                   base_vld_q, base_vld_d;
    logic [DLT_W-1:0]       delta_q,    delta_d;
    logic                   ovf_pend_q, ovf_pend_d;
    logic                   sts_ovf_q,  sts_ovf_d;
    logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
    logic [LVL_W-1:0]       level_q,    level_d;
    logic [BEAT_W-1:0]      beat_q,     beat_d;
    logic                   tvalid_q,   tlast_q,  hpri_q;
    logic [pDATA_WIDTH-1:0] mem_q [pFIFO_DEPTH];

    logic                   diff_s, hb_s, event_s, full_s, pop_s, push_s, drop_s;
    logic [DLT_W-1:0]       delta_inc_s, word_delta_s;
    logic [pDATA_WIDTH-1:0] word_s;

    assign diff_s = |((la_q ^ base_q) & cfg_mask);
`ifdef LA_CAPTURE_HEARTBEAT_EN
    assign hb_s = base_vld_q & (delta_q == DLT_MAX);
`else
    assign hb_s = 1'b0;
`endif
    // A fresh baseline is taken from the first sample after reset or enable.
    assign event_s = cfg_en & smp_vld_q & (~base_vld_q | diff_s | hb_s);
    assign full_s  = (level_q == LVL_FULL);
    assign pop_s   = tvalid_q & la_as.as_la_tready;
    assign push_s  = event_s & (~full_s | pop_s);
    assign drop_s  = event_s & full_s & ~pop_s;

    // delta_q counts edges elapsed since the last push; the word reports the
    // distance including the current edge, and 0 when it has no predecessor.
    assign delta_inc_s  = (delta_q == DLT_MAX) ? DLT_MAX : delta_q + {{(DLT_W-1){1'b0}}, 1'b1};
    assign word_delta_s = base_vld_q ? delta_inc_s : {DLT_W{1'b0}};
    assign word_s       = {ovf_pend_q, word_delta_s, la_q};

    // Probe sampling register, free running.
    always_ff @(posedge axis_clk) begin
        la_q <= la_data;
    end

    // Capture FIFO storage; stale entries are harmless because pointers reset.
    always_ff @(posedge axis_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= word_s;
        end
    end

    // Next-state for change detection, FIFO bookkeeping and burst counting.
    always_comb begin
        base_d     = base_q;
        base_vld_d = base_vld_q;
        delta_d    = delta_q;
        ovf_pend_d = ovf_pend_q;
        sts_ovf_d  = sts_ovf_q | drop_s;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        beat_d     = beat_q;

        if (event_s) begin
            base_d     = la_q;
            base_vld_d = 1'b1;
            delta_d    = {DLT_W{1'b0}};
        end else if (cfg_en) begin
            delta_d    = delta_inc_s;
        end else begin
            base_vld_d = 1'b0;
        end

        if (drop_s) begin
            ovf_pend_d = 1'b1;
        end else if (push_s) begin
            ovf_pend_d = 1'b0;
        end else begin
            ovf_pend_d = ovf_pend_q;
        end

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            beat_d   = (beat_q == BEAT_LAST) ? {BEAT_W{1'b0}} : beat_q + {{(BEAT_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
            beat_d   = beat_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
    end

    // State and registered output update with synchronous reset.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            smp_vld_q  <= 1'b0;
            base_q     <= {pLA_WIDTH{1'b0}};
            base_vld_q <= 1'b0;
            delta_q    <= {DLT_W{1'b0}};
            ovf_pend_q <= 1'b0;
            sts_ovf_q  <= 1'b0;
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            beat_q     <= {BEAT_W{1'b0}};
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            hpri_q     <= 1'b0;
        end else begin
            smp_vld_q  <= 1'b1;
            base_q     <= base_d;
            base_vld_q <= base_vld_d;
            delta_q    <= delta_d;
            ovf_pend_q <= ovf_pend_d;
            sts_ovf_q  <= sts_ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            beat_q     <= beat_d;
            tvalid_q   <= (level_d != {LVL_W{1'b0}});
            tlast_q    <= (beat_d == BEAT_LAST);
            hpri_q     <= (cfg_hpri_th != 4'd0) & ({{(4-LVL_W){1'b0}}, level_d} >= cfg_hpri_th);
        end
    end

    assign la_as.la_as_tdata  = mem_q[rd_ptr_q];
    assign la_as.la_as_tstrb  = {(pDATA_WIDTH/8){1'b1}};
    assign la_as.la_as_tkeep  = {(pDATA_WIDTH/8){1'b1}};
    assign la_as.la_as_tlast  = tlast_q;
    assign la_as.la_as_tvalid = tvalid_q;
    assign la_as.la_as_tuser  = 2'b00;
    assign la_as.la_hpri_req  = hpri_q;
    assign sts_level          = {{(4-LVL_W){1'b0}}, level_q};
    assign sts_ovf            = sts_ovf_q;
endmodule

// File: tb/tb_la_capture_stream.sv
// Directed bench for la_capture_stream: change capture, delta, masking,
// overflow, high-priority request, burst framing and enable handling.
module tb_la_capture_stream;
    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] la;
    logic        cfg_en;
    logic [23:0] mask;
    logic [3:0]  th;
    logic [3:0]  level;
    logic        ovf;
    int          n_total = 0;
    int          n_bad   = 0;
    int          hb_seen;
    int          hb_exp;

    la_capture_stream_if #(.pDATA_WIDTH(32)) bus ();

    la_capture_stream dut (
        .axis_clk    (clk),
        .axis_rst    (rst),
        .la_data     (la),
        .cfg_en      (cfg_en),
        .cfg_mask    (mask),
        .cfg_hpri_th (th),
        .la_as       (bus),
        .sts_level   (level),
        .sts_ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cfg_en = 1'b1; mask = 24'hFFFFFF; th = 4'd0; la = 24'h0;
        bus.as_la_tready = 1'b1;
        repeat (3) step();
        chk("rst_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        chk("rst_tlast",  {31'd0, bus.la_as_tlast},  32'd0);
        chk("rst_hpri",   {31'd0, bus.la_hpri_req},  32'd0);
        chk("rst_level",  {28'd0, level}, 32'd0);
        chk("rst_ovf",    {31'd0, ovf},   32'd0);
        chk("const_tstrb", {28'd0, bus.la_as_tstrb}, 32'hF);
        chk("const_tkeep", {28'd0, bus.la_as_tkeep}, 32'hF);
        chk("const_tuser", {30'd0, bus.la_as_tuser}, 32'd0);
        rst = 1'b0;

        // Test 1: first sample after reset is pushed at edge 2.
        step();
        chk("t1_e1_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        step();
        chk("t1_e2_tvalid", {31'd0, bus.la_as_tvalid}, 32'd1);
        chk("t1_e2_tdata",  bus.la_as_tdata, 32'h0000_0000);
        chk("t1_e2_level",  {28'd0, level}, 32'd1);
        chk("t1_e2_tlast",  {31'd0, bus.la_as_tlast}, 32'd0);
        step();
        chk("t1_e3_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);

        // Test 2: sample 5 (delta 3 after edge-2 push), then 6 with delta 10.
        la = 24'h000005;
        step(); step();
        chk("t2_w5", bus.la_as_tdata, 32'h0300_0005);
        chk("t2_w5_valid", {31'd0, bus.la_as_tvalid}, 32'd1);
        repeat (8) step();
        chk("t2_idle_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        la = 24'h000006;
        step(); step();
        chk("t2_w6", bus.la_as_tdata, 32'h0A00_0006);
        chk("t2_w6_valid", {31'd0, bus.la_as_tvalid}, 32'd1);
        step();

        // Test 3: masked-out bit 8 is ignored, bit 0 gives one push.
        mask = 24'h0000FF;
        la = 24'h000106;
        repeat (4) step();
        chk("t3_masked_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        la = 24'h000107;
        step(); step();
        chk("t3_push_valid",  {31'd0, bus.la_as_tvalid}, 32'd1);
        chk("t3_push_sample", {8'd0, bus.la_as_tdata[23:0]}, 32'h000107);
        step();
        chk("t3_one_push", {31'd0, bus.la_as_tvalid}, 32'd0);
        repeat (3) step();
        chk("t3_level", {28'd0, level}, 32'd0);

        // Test 4: overflow with 10 events into 8 entries.
        mask = 24'hFFFFFF;
        bus.as_la_tready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            la = 24'h000010 + 24'(i);
            step();
        end
        step(); step();
        chk("t4_level_full", {28'd0, level}, 32'd8);
        chk("t4_ovf",        {31'd0, ovf},   32'd1);
        chk("t4_hpri_th0",   {31'd0, bus.la_hpri_req}, 32'd0);
        bus.as_la_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_drain_sample", {8'd0, bus.la_as_tdata[23:0]}, 32'h10 + 32'(i));
            chk("t4_drain_ovfbit", {31'd0, bus.la_as_tdata[31]}, 32'd0);
            step();
        end
        chk("t4_drained", {31'd0, bus.la_as_tvalid}, 32'd0);
        la = 24'h000020;
        step(); step();
        chk("t4_ovf_word_valid",  {31'd0, bus.la_as_tvalid}, 32'd1);
        chk("t4_ovf_word_bit",    {31'd0, bus.la_as_tdata[31]}, 32'd1);
        chk("t4_ovf_word_sample", {8'd0, bus.la_as_tdata[23:0]}, 32'h20);
        step();
        la = 24'h000021;
        step(); step();
        chk("t4_next_ovfbit", {31'd0, bus.la_as_tdata[31]}, 32'd0);
        chk("t4_sticky_ovf",  {31'd0, ovf}, 32'd1);
        step();

        // Test 5: high-priority request follows the next level.
        th = 4'd4;
        bus.as_la_tready = 1'b0;
        la = 24'h000030; step();
        la = 24'h000031; step();
        la = 24'h000032; step();
        la = 24'h000033; step();
        chk("t5_level3", {28'd0, level}, 32'd3);
        chk("t5_hpri_lo", {31'd0, bus.la_hpri_req}, 32'd0);
        step();
        chk("t5_level4", {28'd0, level}, 32'd4);
        chk("t5_hpri_hi", {31'd0, bus.la_hpri_req}, 32'd1);
        bus.as_la_tready = 1'b1;
        step();
        chk("t5_level_after_pop", {28'd0, level}, 32'd3);
        chk("t5_hpri_drop", {31'd0, bus.la_hpri_req}, 32'd0);
        repeat (3) step();
        chk("t5_empty", {28'd0, level}, 32'd0);
        th = 4'd0;

        // Test 6: reset mid-burst, then 8 words framed as two packets.
        rst = 1'b1;
        step(); step();
        chk("t6_rst_level",  {28'd0, level}, 32'd0);
        chk("t6_rst_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        chk("t6_rst_tlast",  {31'd0, bus.la_as_tlast}, 32'd0);
        chk("t6_rst_ovf",    {31'd0, ovf}, 32'd0);
        bus.as_la_tready = 1'b0;
        la = 24'h000040;
        rst = 1'b0;
        step();
        for (int v = 1; v < 8; v++) begin
            la = 24'h000040 + 24'(v);
            step();
        end
        step();
        chk("t6_level8", {28'd0, level}, 32'd8);
        for (int k = 0; k < 8; k++) begin
            chk("t6_data", {8'd0, bus.la_as_tdata[23:0]}, 32'h40 + 32'(k));
            chk("t6_last", {31'd0, bus.la_as_tlast}, (k % 4 == 3) ? 32'd1 : 32'd0);
            if (k == 3 || k == 5) begin
                bus.as_la_tready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    step();
                    chk("t6_stall_valid", {31'd0, bus.la_as_tvalid}, 32'd1);
                    chk("t6_stall_data", {8'd0, bus.la_as_tdata[23:0]}, 32'h40 + 32'(k));
                    chk("t6_stall_last", {31'd0, bus.la_as_tlast}, (k % 4 == 3) ? 32'd1 : 32'd0);
                end
            end
            bus.as_la_tready = 1'b1;
            step();
        end
        chk("t6_drained", {31'd0, bus.la_as_tvalid}, 32'd0);

        // Test 7: idle probes; only the heartbeat build emits a word.
`ifdef LA_CAPTURE_HEARTBEAT_EN
        hb_exp = 1;
`else
        hb_exp = 0;
`endif
        hb_seen = 0;
        for (int c = 0; c < 140; c++) begin
            if (bus.la_as_tvalid) begin
                hb_seen++;
                chk("t7_hb_delta",  {25'd0, bus.la_as_tdata[30:24]}, 32'd127);
                chk("t7_hb_sample", {8'd0, bus.la_as_tdata[23:0]}, 32'h47);
            end
            step();
        end
        chk("t7_word_count", 32'(hb_seen), 32'(hb_exp));

        // Disable: no capture; re-enable: first sample pushed with delta 0.
        cfg_en = 1'b0;
        la = 24'h000050;
        repeat (4) step();
        chk("en_off_tvalid", {31'd0, bus.la_as_tvalid}, 32'd0);
        cfg_en = 1'b1;
        step();
        chk("en_on_valid", {31'd0, bus.la_as_tvalid}, 32'd1);
        chk("en_on_word",  bus.la_as_tdata, 32'h0000_0050);
        step();
        chk("en_on_single", {31'd0, bus.la_as_tvalid}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
